// File: rtl/timer_bank.sv
// Three independent one-shot interval timers for the LED blink sequencer.
// Latency: tN_int_out pulses in the cycle after arm edge + PRESCALE*Tn_TICKS.
// Backpressure: none; start inputs are levels and expiry is a one-cycle pulse.
//
// Ports:
//   clock_in            single system clock, rising edge
//   reset_in            synchronous reset, active-high
//   t0/t1/t2_start_in   start levels; a 0->1 edge arms, staying high keeps the timer running
//   t0/t1/t2_int_out    one-cycle registered pulse at expiry
//   t0/t1/t2_busy_out   registered, high while the timer is running

// One timer channel: prescaler plus tick counter with a two-state FSM.
module timer_bank_chan #(
    parameter int          PRE_W    = 16,
    parameter int          CNT_W    = 24,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned TICKS    = 500
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic start_in,
    output logic int_out,
    output logic busy_out
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Values loaded on arm. Both counters count down to zero and are tested
    // before they are decremented, so a full interval is PRESCALE*TICKS edges.
    localparam logic [PRE_W-1:0] PRE_RELOAD = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(TICKS - 1);
    localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q,   pre_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               start_q, start_d;
    logic               int_q,   int_d;
    logic               busy_q,  busy_d;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        int_d   = 1'b0;
        start_d = start_in;

        case (state_q)
            ST_IDLE: begin
                // Arm only on a rising edge; a start left high after expiry
                // does not re-trigger.
                if (start_in && !start_q) begin
                    state_d = ST_RUN;
                    pre_d   = PRE_RELOAD;
                    cnt_d   = CNT_RELOAD;
                end
            end
            ST_RUN: begin
                // Dropping start aborts, even on the edge that would expire.
                if (!start_in) begin
                    state_d = ST_IDLE;
                end else if (pre_q != '0) begin
                    pre_d = pre_q - PRE_ONE;
                end else if (cnt_q != '0) begin
                    pre_d = PRE_RELOAD;
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                    int_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            int_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            int_q   <= int_d;
            busy_q  <= busy_d;
        end
    end

    assign int_out  = int_q;
    assign busy_out = busy_q;

endmodule

module timer_bank #(
    parameter int          PRE_W    = 16,
    parameter int          CNT_W    = 24,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned T0_TICKS = 500,
    parameter int unsigned T1_TICKS = 500,
    parameter int unsigned T2_TICKS = 2000
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic t0_start_in,
    input  logic t1_start_in,
    input  logic t2_start_in,
    output logic t0_int_out,
    output logic t1_int_out,
    output logic t2_int_out,
    output logic t0_busy_out,
    output logic t1_busy_out,
    output logic t2_busy_out
);

    // T0: OFF phase
    timer_bank_chan #(
        .PRE_W    (PRE_W),
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE),
        .TICKS    (T0_TICKS)
    ) u_t0 (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .start_in (t0_start_in),
        .int_out  (t0_int_out),
        .busy_out (t0_busy_out)
    );

    // T1: ON phase
    timer_bank_chan #(
        .PRE_W    (PRE_W),
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE),
        .TICKS    (T1_TICKS)
    ) u_t1 (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .start_in (t1_start_in),
        .int_out  (t1_int_out),
        .busy_out (t1_busy_out)
    );

    // T2: IDLE phase
    timer_bank_chan #(
        .PRE_W    (PRE_W),
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE),
        .TICKS    (T2_TICKS)
    ) u_t2 (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .start_in (t2_start_in),
        .int_out  (t2_int_out),
        .busy_out (t2_busy_out)
    );

endmodule
